// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch bus between the fetch stage and memory.
// The stage issues req/addr; memory answers with ack/data.
interface if_fetch_stage_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemAck,
        input  IMemData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemAck,
        output IMemData
    );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC, fetch FSM and IF/ID register.
// Handles stall buffering, flush on redirect and late-ack redirects.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [31:0]              NextPC,
    input  logic                     PCSrc,
    input  logic                     Stall,
    if_fetch_stage_if.master         imem,
    output logic [31:0]              PCPlus4,
    output logic [31:0]              IF_ID_Instr,
    output logic [31:0]              IF_ID_PCPlus4,
    output logic                     IF_ID_Valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] target;

    // Combinational outputs: sequential PC and the memory request.
    always_comb begin
        pc_plus4      = pc_q + 32'd4;
        target        = NextPC & 32'hFFFF_FFFC;
        PCPlus4       = pc_plus4;
        imem.IMemAddr = pc_q;
        imem.IMemReq  = (state_q != HOLD) && !Reset;
        IF_ID_Instr   = ifid_instr_q;
        IF_ID_PCPlus4 = ifid_pc4_q;
        IF_ID_Valid   = ifid_valid_q;
    end

    // Next-state logic for the fetch FSM, PC, buffers and IF/ID.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        buf_instr_d  = buf_instr_q;
        buf_pc4_d    = buf_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;

        unique case (state_q)
            FETCH: begin
                if (PCSrc) begin
                    if (imem.IMemAck) begin
                        pc_d = target;
                    end else begin
                        pend_d  = target;
                        state_d = DROP;
                    end
                end else if (imem.IMemAck) begin
                    pc_d = pc_plus4;
                    if (!Stall) begin
                        ifid_instr_d = imem.IMemData;
                        ifid_pc4_d   = pc_plus4;
                        ifid_valid_d = 1'b1;
                    end else begin
                        buf_instr_d = imem.IMemData;
                        buf_pc4_d   = pc_plus4;
                        state_d     = HOLD;
                    end
                end else if (!Stall) begin
                    ifid_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (PCSrc) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (!Stall) begin
                    ifid_instr_d = buf_instr_q;
                    ifid_pc4_d   = buf_pc4_q;
                    ifid_valid_d = 1'b1;
                    state_d      = FETCH;
                end
            end
            DROP: begin
                if (imem.IMemAck) begin
                    pc_d    = PCSrc ? target : pend_q;
                    state_d = FETCH;
                end else if (PCSrc) begin
                    pend_d = target;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // A redirect squashes whatever IF/ID holds, even under stall.
        if (PCSrc) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = 32'h0;
        end
    end

    // State registers with synchronous reset; reset also masks any ack.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            pend_q       <= 32'h0;
            buf_instr_q  <= 32'h0;
            buf_pc4_q    <= 32'h0;
            ifid_instr_q <= 32'h0;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc4_q    <= buf_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage.
// Second instance uses RESET_PC near the top of memory for wrap checks.
module tb_if_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] next_pc;
    logic        pc_src;
    logic        stall;

    logic [31:0] pc4_a, instr_a, ifpc4_a;
    logic        valid_a;
    logic [31:0] pc4_b, instr_b, ifpc4_b;
    logic        valid_b;

    int pass_cnt;
    int total_cnt;

    if_fetch_stage_if bus_a ();
    if_fetch_stage_if bus_b ();

    if_fetch_stage dut_a (
        .Clk           (clk),
        .Reset         (reset),
        .NextPC        (next_pc),
        .PCSrc         (pc_src),
        .Stall         (stall),
        .imem          (bus_a),
        .PCPlus4       (pc4_a),
        .IF_ID_Instr   (instr_a),
        .IF_ID_PCPlus4 (ifpc4_a),
        .IF_ID_Valid   (valid_a)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .Clk           (clk),
        .Reset         (reset),
        .NextPC        (next_pc),
        .PCSrc         (pc_src),
        .Stall         (stall),
        .imem          (bus_b),
        .PCPlus4       (pc4_b),
        .IF_ID_Instr   (instr_b),
        .IF_ID_PCPlus4 (ifpc4_b),
        .IF_ID_Valid   (valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pc_src = 1'b0;
        stall = 1'b0;
        next_pc = 32'h0;
        bus_a.IMemAck = 1'b0;
        bus_a.IMemData = 32'h0;
        bus_b.IMemAck = 1'b0;
        bus_b.IMemData = 32'h0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_a.IMemAck = 1'b1;
        bus_a.IMemData = 32'hAAAA_5555;
        step();
        total_cnt++;
        if (bus_a.IMemAddr !== 32'h0)
            $display("FAIL rst_addr got %h exp %h", bus_a.IMemAddr, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (bus_a.IMemReq !== 1'b0)
            $display("FAIL rst_req got %b exp 0", bus_a.IMemReq);
        else pass_cnt++;
        total_cnt++;
        if (valid_a !== 1'b0 || instr_a !== 32'h0 || ifpc4_a !== 32'h0)
            $display("FAIL rst_ifid got %b %h %h exp 0 0 0",
                     valid_a, instr_a, ifpc4_a);
        else pass_cnt++;
        reset = 1'b0;
        bus_a.IMemAck = 1'b0;
        #1;
        total_cnt++;
        if (bus_a.IMemReq !== 1'b1)
            $display("FAIL rst_req_after got %b exp 1", bus_a.IMemReq);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a = 32'(i) * 32'd4;
            bus_a.IMemAck = 1'b1;
            bus_a.IMemData = a;
            #1;
            total_cnt++;
            if (bus_a.IMemAddr !== a || pc4_a !== a + 32'd4)
                $display("FAIL stream_addr got %h/%h exp %h/%h",
                         bus_a.IMemAddr, pc4_a, a, a + 32'd4);
            else pass_cnt++;
            step();
            total_cnt++;
            if (valid_a !== 1'b1 || instr_a !== a || ifpc4_a !== a + 32'd4)
                $display("FAIL stream_ifid got %b %h %h exp 1 %h %h",
                         valid_a, instr_a, ifpc4_a, a, a + 32'd4);
            else pass_cnt++;
        end
        bus_a.IMemAck = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        bus_a.IMemAck = 1'b1;
        bus_a.IMemData = 32'h0;
        step();
        bus_a.IMemData = 32'h4;
        step();
        bus_a.IMemData = 32'h8;
        stall = 1'b1;
        step();
        bus_a.IMemAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (instr_a !== 32'h4 || ifpc4_a !== 32'h8 || valid_a !== 1'b1)
                $display("FAIL stall_frozen got %h %h %b exp 4 8 1",
                         instr_a, ifpc4_a, valid_a);
            else pass_cnt++;
            total_cnt++;
            if (bus_a.IMemReq !== 1'b0)
                $display("FAIL stall_req got %b exp 0", bus_a.IMemReq);
            else pass_cnt++;
            if (i < 2) step();
        end
        stall = 1'b0;
        step();
        total_cnt++;
        if (instr_a !== 32'h8 || ifpc4_a !== 32'hC || valid_a !== 1'b1)
            $display("FAIL stall_release got %h %h %b exp 8 c 1",
                     instr_a, ifpc4_a, valid_a);
        else pass_cnt++;
        total_cnt++;
        if (bus_a.IMemAddr !== 32'hC || bus_a.IMemReq !== 1'b1)
            $display("FAIL stall_next got %h %b exp c 1",
                     bus_a.IMemAddr, bus_a.IMemReq);
        else pass_cnt++;
    endtask

    task automatic test_redirect_drop();
        do_reset();
        bus_a.IMemAck = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_a.IMemData = 32'(i) * 32'd4;
            step();
        end
        bus_a.IMemAck = 1'b0;
        pc_src = 1'b1;
        next_pc = 32'h40;
        step();
        pc_src = 1'b0;
        next_pc = 32'h0;
        total_cnt++;
        if (bus_a.IMemAddr !== 32'h10 || bus_a.IMemReq !== 1'b1)
            $display("FAIL drop_hold_addr got %h %b exp 10 1",
                     bus_a.IMemAddr, bus_a.IMemReq);
        else pass_cnt++;
        total_cnt++;
        if (valid_a !== 1'b0 || instr_a !== 32'h0)
            $display("FAIL drop_flush got %b %h exp 0 0", valid_a, instr_a);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus_a.IMemAddr !== 32'h10 || valid_a !== 1'b0)
            $display("FAIL drop_wait got %h %b exp 10 0",
                     bus_a.IMemAddr, valid_a);
        else pass_cnt++;
        bus_a.IMemAck = 1'b1;
        bus_a.IMemData = 32'hDEAD_BEEF;
        step();
        total_cnt++;
        if (bus_a.IMemAddr !== 32'h40 || valid_a !== 1'b0)
            $display("FAIL drop_target got %h %b exp 40 0",
                     bus_a.IMemAddr, valid_a);
        else pass_cnt++;
        bus_a.IMemData = 32'h40;
        step();
        total_cnt++;
        if (valid_a !== 1'b1 || instr_a !== 32'h40 || ifpc4_a !== 32'h44)
            $display("FAIL drop_resume got %b %h %h exp 1 40 44",
                     valid_a, instr_a, ifpc4_a);
        else pass_cnt++;
        bus_a.IMemAck = 1'b0;
    endtask

    task automatic test_flush_stall();
        bus_a.IMemAck = 1'b1;
        bus_a.IMemData = 32'h44;
        pc_src = 1'b1;
        next_pc = 32'h83;
        stall = 1'b1;
        step();
        pc_src = 1'b0;
        stall = 1'b0;
        bus_a.IMemAck = 1'b0;
        total_cnt++;
        if (valid_a !== 1'b0 || instr_a !== 32'h0)
            $display("FAIL flush_ifid got %b %h exp 0 0", valid_a, instr_a);
        else pass_cnt++;
        total_cnt++;
        if (bus_a.IMemAddr !== 32'h80 || bus_a.IMemReq !== 1'b1)
            $display("FAIL flush_addr got %h %b exp 80 1",
                     bus_a.IMemAddr, bus_a.IMemReq);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset();
        total_cnt++;
        if (bus_b.IMemAddr !== 32'hFFFF_FFFC || pc4_b !== 32'h0)
            $display("FAIL wrap_pc got %h %h exp fffffffc 0",
                     bus_b.IMemAddr, pc4_b);
        else pass_cnt++;
        bus_b.IMemAck = 1'b1;
        bus_b.IMemData = 32'h1234_5678;
        step();
        bus_b.IMemAck = 1'b0;
        total_cnt++;
        if (bus_b.IMemAddr !== 32'h0 || pc4_b !== 32'h4)
            $display("FAIL wrap_next got %h %h exp 0 4",
                     bus_b.IMemAddr, pc4_b);
        else pass_cnt++;
        total_cnt++;
        if (valid_b !== 1'b1 || instr_b !== 32'h1234_5678 || ifpc4_b !== 32'h0)
            $display("FAIL wrap_ifid got %b %h %h exp 1 12345678 0",
                     valid_b, instr_b, ifpc4_b);
        else pass_cnt++;
    endtask

    task automatic test_reset_drop();
        do_reset();
        bus_a.IMemAck = 1'b1;
        bus_a.IMemData = 32'h0;
        step();
        bus_a.IMemAck = 1'b0;
        pc_src = 1'b1;
        next_pc = 32'h100;
        step();
        pc_src = 1'b0;
        reset = 1'b1;
        bus_a.IMemAck = 1'b1;
        bus_a.IMemData = 32'hBAD0_BAD0;
        step();
        total_cnt++;
        if (valid_a !== 1'b0 || instr_a !== 32'h0 || ifpc4_a !== 32'h0 ||
            bus_a.IMemReq !== 1'b0)
            $display("FAIL rdrop_outs got %b %h %h %b exp 0 0 0 0",
                     valid_a, instr_a, ifpc4_a, bus_a.IMemReq);
        else pass_cnt++;
        reset = 1'b0;
        bus_a.IMemAck = 1'b0;
        #1;
        total_cnt++;
        if (bus_a.IMemAddr !== 32'h0 || bus_a.IMemReq !== 1'b1)
            $display("FAIL rdrop_addr got %h %b exp 0 1",
                     bus_a.IMemAddr, bus_a.IMemReq);
        else pass_cnt++;
        bus_a.IMemAck = 1'b1;
        bus_a.IMemData = 32'h0;
        step();
        bus_a.IMemAck = 1'b0;
        total_cnt++;
        if (valid_a !== 1'b1 || instr_a !== 32'h0 || ifpc4_a !== 32'h4 ||
            bus_a.IMemAddr !== 32'h4)
            $display("FAIL rdrop_resume got %b %h %h %h exp 1 0 4 4",
                     valid_a, instr_a, ifpc4_a, bus_a.IMemAddr);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        reset = 1'b1;
        pc_src = 1'b0;
        stall = 1'b0;
        next_pc = 32'h0;
        bus_a.IMemAck = 1'b0;
        bus_a.IMemData = 32'h0;
        bus_b.IMemAck = 1'b0;
        bus_b.IMemData = 32'h0;
        #2;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_flush_stall();
        test_wrap();
        test_reset_drop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
